// File: rtl/sign_extend_arbiter.sv
// sign_extend_arbiter
//
// Several requesters share one sign-extension datapath. The arbiter picks one
// requester per cycle in round-robin order. It widens that requester's operand
// from INPUT_WIDTH to OUTPUT_WIDTH and registers the result. The result leaves
// on a single valid/ready port, tagged with the index of the requester that
// produced it.
//
// Optional feature (macro SEXT_ZEXT_MODE_EN):
//   defined   - adds port req_zext; a set bit zero-extends that requester's operand.
//   undefined - req_zext is absent; every operand is sign-extended.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous reset, active-high
//   req_valid  - per-requester request valid
//   req_ready  - per-requester accept; one-hot or all zero
//   req_data   - operands packed side by side; requester i is at [i*INPUT_WIDTH +: INPUT_WIDTH]
//   req_zext   - per-requester zero-extend select (SEXT_ZEXT_MODE_EN only)
//   out_valid  - the result register holds a result
//   out_ready  - downstream accepts the result
//   out_data   - extended result
//   out_id     - index of the requester that produced out_data

module sign_extend_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned INPUT_WIDTH  = 8,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned ID_WIDTH     = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data,
`ifdef SEXT_ZEXT_MODE_EN
    input  logic [NUM_REQ-1:0]             req_zext,
`endif
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUTPUT_WIDTH-1:0]        out_data,
    output logic [ID_WIDTH-1:0]            out_id
);

    logic                    out_valid_q, out_valid_d;
    logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]     out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;

    logic                    out_free;
    logic                    found_hi, found_lo;
    logic [ID_WIDTH-1:0]     idx_hi, idx_lo;
    logic                    grant_found;
    logic [ID_WIDTH-1:0]     grant_idx;
    logic [NUM_REQ-1:0]      grant_oh;
    logic [INPUT_WIDTH-1:0]  sel_data;
    logic                    sel_fill;
    logic                    xfer;

    // The result register can take a new value when it is empty or is being drained now.
    assign out_free = !out_valid_q || out_ready;

    // Round-robin scan done as two priority searches. The first looks for the lowest set
    // bit at or above rr_ptr. If there is none, the second wraps to the lowest set bit
    // overall.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !found_lo) begin
                found_lo = 1'b1;
                idx_lo   = ID_WIDTH'(i);
            end
            if (req_valid[i] && !found_hi && (i >= 32'(rr_ptr_q))) begin
                found_hi = 1'b1;
                idx_hi   = ID_WIDTH'(i);
            end
        end
        grant_found = found_hi || found_lo;
        grant_idx   = found_hi ? idx_hi : idx_lo;
    end

    // Decode the grant and select the granted operand and its fill bit.
    always_comb begin
        grant_oh = '0;
        sel_data = '0;
        sel_fill = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_found && (32'(grant_idx) == i)) begin
                grant_oh[i] = 1'b1;
                sel_data    = req_data[i*INPUT_WIDTH +: INPUT_WIDTH];
`ifdef SEXT_ZEXT_MODE_EN
                sel_fill    = req_data[i*INPUT_WIDTH + INPUT_WIDTH - 1] & ~req_zext[i];
`else
                sel_fill    = req_data[i*INPUT_WIDTH + INPUT_WIDTH - 1];
`endif
            end
        end
    end

    assign xfer      = !rst && out_free && grant_found;
    assign req_ready = xfer ? grant_oh : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            // A drain and a new accept in the same cycle simply overwrite the register.
            out_valid_d = 1'b1;
            out_data_d  = {{(OUTPUT_WIDTH - INPUT_WIDTH){sel_fill}}, sel_data};
            out_id_d    = grant_idx;
            rr_ptr_d    = (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (out_valid_q && out_ready) begin
            // Data and id hold their last values after a drain.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_sign_extend_arbiter.sv
// Testbench for sign_extend_arbiter. A reference model is updated on each rising edge
// and compared with the design on every falling edge. Directed steps add literal
// expectations that pin the model.
module tb_sign_extend_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned OW = 16;
    localparam int unsigned IDW = 2;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IW-1:0]   req_data;
`ifdef SEXT_ZEXT_MODE_EN
    logic [N-1:0]      req_zext;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic [IDW-1:0]    out_id;

    int checks = 0;
    int errors = 0;

    sign_extend_arbiter #(
        .NUM_REQ      (N),
        .INPUT_WIDTH  (IW),
        .OUTPUT_WIDTH (OW),
        .ID_WIDTH     (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
`ifdef SEXT_ZEXT_MODE_EN
        .req_zext  (req_zext),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Returns the first valid requester at or after ptr, wrapping modulo N; -1 if none.
    function automatic int find_grant(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < int'(N); k++) begin
            int idx;
            idx = (ptr + k) % int'(N);
            if (v[idx] === 1'b1) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] get_byte(input logic [N*IW-1:0] d, input int idx);
        return d[idx*8 +: 8];
    endfunction

    function automatic logic [15:0] extend(input logic [7:0] d, input logic z);
        logic signed [15:0] s;
        s = $signed(d);
        return z ? {8'h00, d} : s;
    endfunction

    function automatic logic zbit(input int idx);
`ifdef SEXT_ZEXT_MODE_EN
        return req_zext[idx];
`else
        return 1'b0 & idx[0];
`endif
    endfunction

    logic        m_started = 1'b0;
    logic        m_valid   = 1'b0;
    logic [15:0] m_data    = '0;
    logic [1:0]  m_id      = '0;
    int          m_ptr     = 0;
    int          m_g;
    logic        m_free;
    logic [N-1:0] exp_ready;

    assign m_g       = find_grant(req_valid, m_ptr);
    assign m_free    = !m_valid || out_ready;
    assign exp_ready = (rst || !m_free || m_g < 0) ? 4'b0000 : (4'b0001 << m_g);

    always @(posedge clk) begin
        if (rst) begin
            m_started <= 1'b1;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_id      <= '0;
            m_ptr     <= 0;
        end else if (m_free && m_g >= 0) begin
            m_valid <= 1'b1;
            m_data  <= extend(get_byte(req_data, m_g), zbit(m_g));
            m_id    <= 2'(m_g);
            m_ptr   <= (m_g + 1) % int'(N);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("model_req_ready", 32'(req_ready), 32'(exp_ready));
            check("model_out_valid", 32'(out_valid), 32'(m_valid));
            check("model_out_data",  32'(out_data),  32'(m_data));
            check("model_out_id",    32'(out_id),    32'(m_id));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  tbl_v [12] = '{4'hF, 4'hF, 4'h5, 4'h5, 4'hA, 4'h0,
                                4'h8, 4'h3, 4'hF, 4'h1, 4'h6, 4'hF};
    logic        tbl_r [12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int          exp_ids [5] = '{0, 1, 2, 3, 0};
    logic [15:0] held_exp;

    initial begin
        rst       = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        out_ready = 1'b1;
`ifdef SEXT_ZEXT_MODE_EN
        req_zext  = '0;
        held_exp  = 16'h0085;
`else
        held_exp  = 16'hFF85;
`endif

        // Reset with every requester asking: nothing may be accepted.
        @(negedge clk);
        check("t1_ready_in_reset_a", 32'(req_ready), 32'h0);
        tick();
        @(negedge clk);
        check("t1_ready_in_reset_b", 32'(req_ready), 32'h0);
        tick();
        rst       = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        check("t1_out_valid", 32'(out_valid), 32'h0);
        check("t1_out_data",  32'(out_data),  32'h0);
        check("t1_out_id",    32'(out_id),    32'h0);

        // Single request from requester 0 with a negative operand.
        tick();
        req_valid = 4'b0001;
        req_data[0*8 +: 8] = 8'h85;
        @(negedge clk);
        check("t2_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        check("t2_valid", 32'(out_valid), 32'h1);
        check("t2_data",  32'(out_data),  32'hFF85);
        check("t2_id",    32'(out_id),    32'h0);

        // Positive operand from requester 2.
        tick();
        req_valid = 4'b0100;
        req_data[2*8 +: 8] = 8'h7F;
        @(negedge clk);
        check("t3_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        check("t3_data", 32'(out_data), 32'h007F);
        check("t3_id",   32'(out_id),   32'h2);

        // Round-robin with everyone requesting after a reset.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < int'(N); i++) req_data[i*8 +: 8] = 8'h10 + 8'(i);
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            tick();
            @(negedge clk);
            check("t4_valid", 32'(out_valid), 32'h1);
            check("t4_id",    32'(out_id),    32'(exp_ids[k]));
        end
        tick();
        req_valid = 4'h0;

        // Load a result from requester 3, then hold it under backpressure.
        tick();
        req_valid = 4'b1000;
        req_data[3*8 +: 8] = 8'h85;
`ifdef SEXT_ZEXT_MODE_EN
        req_zext[3] = 1'b1;
`endif
        @(negedge clk);
        check("t5_load_ready", 32'(req_ready), 32'h8);
        tick();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[1*8 +: 8] = 8'h12;
`ifdef SEXT_ZEXT_MODE_EN
        req_zext = '0;
`endif
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            check("t5_hold_ready", 32'(req_ready), 32'h0);
            check("t5_hold_data",  32'(out_data),  32'(held_exp));
            check("t5_hold_id",    32'(out_id),    32'h3);
            check("t5_hold_valid", 32'(out_valid), 32'h1);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_accept_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        check("t5_new_id",   32'(out_id),   32'h1);
        check("t5_new_data", 32'(out_data), 32'h0012);

        // Same operand on requester 3 with sign extension selected.
        tick();
        req_valid = 4'b1000;
        tick();
        req_valid = 4'h0;
        @(negedge clk);
        check("t6_sext_data", 32'(out_data), 32'hFF85);
        check("t6_sext_id",   32'(out_id),   32'h3);

        // Reset while a result is held discards it.
        tick();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'h0;
        out_ready = 1'b0;
        @(negedge clk);
        check("t7_loaded", 32'(out_valid), 32'h1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("t7_ready_in_reset", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t7_valid_after", 32'(out_valid), 32'h0);
        check("t7_data_after",  32'(out_data),  32'h0);

        // Mixed request and backpressure vectors, checked by the model.
        req_data = 32'hC341807E;
        for (int i = 0; i < 12; i++) begin
            tick();
            req_valid = tbl_v[i];
            out_ready = tbl_r[i];
        end
        tick();
        req_valid = 4'h0;
        out_ready = 1'b1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
